pwm_ramp_ctrl: RTL and testbench
================================

# pwm_ramp_ctrl

Duty-cycle sequencer for the team's `PWM` block. It accepts target-duty requests over a valid/ready handshake and ramps the PWM duty toward each target in fixed steps. Duty and timer reload updates are applied only at PWM period boundaries, so no truncated or glitched pulses are produced. It drives `Final_Value` and `duty` of one `PWM` instance and tracks its tick/phase counters in lockstep.

## Interface
- `R`, 8: PWM resolution; period is 2^R ticks; must equal the PWM's `R`.
- `TIMER`, 16: tick-divider width; must equal the PWM's `Timer`.
- `clk` in 1: clock. Shared with the PWM.
- `reset_n` in 1: asynchronous, active-low reset. Shared with the PWM.
- `cfg_final_value` in TIMER: requested tick divider value; applied only at a period boundary.
- `enable` in 1: run enable. When low, the output is forced to 0 duty at the next boundary.
- `req_valid` in 1: a new target is offered.
- `req_ready` out 1: the block can accept a target.
- `req_duty` in R+1: target duty, 0..2^R; values above 2^R are clamped to 2^R (100 %).
- `req_step` in R: duty change per period; 0 means jump to the target at the next boundary.
- `pwm_final_value` out TIMER: connects to the PWM `Final_Value`. Registered.
- `pwm_duty` out R+1: connects to the PWM `duty`. Registered.
- `period_start` out 1: one-cycle pulse on each boundary tick.
- `busy` out 1: high in the RAMP state.
- `done` out 1: one-cycle pulse when `pwm_duty` reaches the target.

## Operation
- **Tick divider:** `tcnt` counts 0..`pwm_final_value`.
  - `tick` = (`tcnt` == `pwm_final_value`); on a tick, `tcnt` returns to 0.
  - This matches the PWM's internal timer exactly.
- **Phase counter:** `phase` is R bits and increments on each tick, wrapping at 2^R-1.
  - Boundary = `tick` && `phase` == 2^R-1.
  - `period_start` is asserted on the boundary cycle.
- **Boundary register updates:** at every boundary, the following are registered:
  - `pwm_final_value` <= `cfg_final_value`. `tcnt` is 0 on the next cycle in both blocks, so lockstep is kept.
  - `pwm_duty` <= next duty, computed by the FSM.
- **State IDLE:**
  - `req_ready`=1.
  - On `req_valid`&&`req_ready`, latch `target` (clamped) and `step`, then go to RAMP.
- **State RAMP:** at each boundary:
  - If |`target`−`pwm_duty`| <= `step` or `step`==0: `pwm_duty` <= `target`, pulse `done`, go to IDLE.
  - Otherwise, `pwm_duty` moves by `step` toward `target`.
  - Arithmetic is R+2 bit signed difference; no wrap is possible.
- **Disable:**
  - `enable`=0 at a boundary: `pwm_duty` <= 0, `target` <= 0, state <= IDLE, no `done`.
  - `req_ready`=0 while `enable`=0.
- **Target equals current duty:** if an accepted `target` equals `pwm_duty`, `done` pulses at the next boundary with no duty change.

## Timing
- **Reset values:**
  - `pwm_duty`=0, `pwm_final_value`=0, `tcnt`=0, `phase`=0, state IDLE.
  - `req_ready`=0 during reset, then 1 from the first cycle after release if `enable`=1.
  - `busy`=0, `done`=0, `period_start`=0.
- **Reset release:** while `pwm_final_value`=0, a tick occurs every cycle. The first boundary comes 2^R cycles after release and loads `cfg_final_value`.
- **Acceptance latency:** a request accepted at cycle t affects `pwm_duty` at the first boundary after t (the register updates on the boundary edge).
  - If acceptance and boundary coincide, the change is applied at the following boundary.
- **Duty visibility:** the PWM samples the new duty at its phase-0 tick, so every period uses exactly one duty value.
- **Output pulses:** `done` is asserted in the cycle after the boundary edge that reaches the target, for 1 cycle.
- **Reset mid-ramp:** everything returns to the reset values immediately and asynchronously. The pending target is discarded.
- **Simultaneous events:** if `enable` falls on the same boundary as the target is reached, disable wins and `done` is not pulsed.

## Configuration
- **`PWM_RAMP_RETARGET_EN` defined:**
  - `req_ready`=1 in RAMP as well as IDLE.
  - A request accepted in RAMP replaces `target`/`step`; the ramp continues from the current `pwm_duty` at the next boundary.
  - If acceptance coincides with a boundary, that boundary uses the old target.
- **Undefined:** `req_ready`=0 throughout RAMP, and requests are held off until `done`.

## Test plan
1. **Ramp up:** R=8, `cfg_final_value`=1 (period 512 cycles); request duty 64, step 16 from 0.
   - `pwm_duty` = 16, 32, 48, 64 on four consecutive boundaries.
   - `done` pulses once; `busy` falls with it.
2. **Immediate jump and down-ramp:**
   - Step 0, target 200 from 64: 200 at the first boundary.
   - Then target 190, step 4: 196, 192, 190, with the last step clamped to the target.
3. **Clamp:** `req_duty`=300 (R+1 bits) → target 256; `pwm_duty` reaches 256 and the PWM output is constantly high.
4. **Divider change mid-period:** change `cfg_final_value` from 1 to 3 at phase 100.
   - `pwm_final_value` changes only at the boundary.
   - `period_start` spacing goes from 512 to 1024 cycles, and the `PWM` output stays aligned.
5. **Disable and reset during a ramp:**
   - `enable`=0 during a ramp: `pwm_duty`=0 at the next boundary, no `done`.
   - `reset_n` pulse mid-ramp: all outputs return to their reset values in the same cycle.
6. **Retarget:** with `PWM_RAMP_RETARGET_EN`, request 128 step 8, then after 2 boundaries request 0 step 8: 8, 16, then 8, 0.
   - Without the macro, `req_ready`=0 until `done`.

Source files
------------

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: duty-cycle sequencer for one PWM instance.
//   Accepts target-duty requests over valid/ready and walks pwm_duty toward
//   the target by a fixed step per PWM period. pwm_duty and pwm_final_value
//   change only at period boundaries. The tick divider and phase counter run
//   in lockstep with the PWM's own counters.
// Ports:
//   clk, reset_n         clock, async active-low reset (shared with the PWM)
//   cfg_final_value      requested tick divider, loaded at a boundary
//   enable               run enable; low forces 0 duty at the next boundary
//   req_valid/req_ready  target request handshake
//   req_duty, req_step   target duty (clamped to 2^R) and per-period step
//   pwm_final_value      registered divider value to the PWM
//   pwm_duty             registered duty value to the PWM
//   period_start         high during the boundary cycle
//   busy                 high while ramping
//   done                 one-cycle pulse after the boundary that reaches target
// Build option:
//   PWM_RAMP_RETARGET_EN  accept new targets while ramping
module pwm_ramp_ctrl #(
  parameter int unsigned R     = 8,
  parameter int unsigned TIMER = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [TIMER-1:0] cfg_final_value,
  input  logic             enable,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [R:0]       req_duty,
  input  logic [R-1:0]     req_step,
  output logic [TIMER-1:0] pwm_final_value,
  output logic [R:0]       pwm_duty,
  output logic             period_start,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE, RAMP} state_t;

  localparam logic [R:0] FULL_DUTY = {1'b1, {R{1'b0}}};

  state_t           state, state_nxt;
  logic [TIMER-1:0] tcnt;
  logic [R-1:0]     phase;
  logic             tick, boundary;
  logic             run;
  logic [R:0]       target;
  logic [R-1:0]     step;
  logic             accept;
  logic [R:0]       req_clamped;
  logic [R+1:0]     diff, mag;
  logic             reach;
  logic [R:0]       duty_stepped, duty_nxt;

  assign tick         = (tcnt == pwm_final_value);
  assign boundary     = tick && (phase == '1);
  assign period_start = boundary;
  assign accept       = req_valid && req_ready;
  assign req_clamped  = (req_duty > FULL_DUTY) ? FULL_DUTY : req_duty;

  // Distance to target in R+2 bits: top bit is the sign, magnitude cannot wrap.
  assign diff  = {1'b0, target} - {1'b0, pwm_duty};
  assign mag   = diff[R+1] ? (~diff + 1'b1) : diff;
  assign reach = (step == '0) || (mag <= {2'b00, step});
  assign duty_stepped = diff[R+1] ? (pwm_duty - {1'b0, step})
                                  : (pwm_duty + {1'b0, step});

  always_comb begin
    duty_nxt = pwm_duty;
    if (!enable)
      duty_nxt = '0;
    else if (state == RAMP)
      duty_nxt = reach ? target : duty_stepped;
  end

  // Tick divider and phase counter, mirroring the PWM's internal timer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tcnt  <= '0;
      phase <= '0;
    end else if (tick) begin
      tcnt  <= '0;
      phase <= phase + 1'b1;
    end else begin
      tcnt  <= tcnt + 1'b1;
    end
  end

  // Boundary-only register updates plus request latching.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_final_value <= '0;
      pwm_duty        <= '0;
      target          <= '0;
      step            <= '0;
      done            <= 1'b0;
      run             <= 1'b0;
    end else begin
      run  <= 1'b1;
      done <= boundary && enable && (state == RAMP) && reach;
      if (boundary) begin
        pwm_final_value <= cfg_final_value;
        pwm_duty        <= duty_nxt;
      end
      // A request taken on a boundary edge lands after that boundary has
      // already used the old target, so it takes effect one period later.
      if (accept) begin
        target <= req_clamped;
        step   <= req_step;
      end else if (boundary && !enable) begin
        target <= '0;
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // FSM: next state (a fresh request wins over a ramp completing together)
  always_comb begin
    state_nxt = state;
    if (boundary) begin
      if (!enable)
        state_nxt = IDLE;
      else if ((state == RAMP) && reach)
        state_nxt = IDLE;
    end
    if (accept)
      state_nxt = RAMP;
  end

  // FSM: outputs
  always_comb begin
    busy = (state == RAMP);
`ifdef PWM_RAMP_RETARGET_EN
    req_ready = run && enable;
`else
    req_ready = run && enable && (state == IDLE);
`endif
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
module tb_pwm_ramp_ctrl;

  localparam int R     = 8;
  localparam int TIMER = 16;
  localparam int FULL  = 1 << R;
`ifdef PWM_RAMP_RETARGET_EN
  localparam bit RETARGET = 1'b1;
`else
  localparam bit RETARGET = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic [TIMER-1:0] cfg_final_value = '0;
  logic             enable = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [R:0]       req_duty = '0;
  logic [R-1:0]     req_step = '0;
  logic [TIMER-1:0] pwm_final_value;
  logic [R:0]       pwm_duty;
  logic             period_start;
  logic             busy;
  logic             done;

  pwm_ramp_ctrl #(.R(R), .TIMER(TIMER)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .cfg_final_value (cfg_final_value),
    .enable          (enable),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_duty        (req_duty),
    .req_step        (req_step),
    .pwm_final_value (pwm_final_value),
    .pwm_duty        (pwm_duty),
    .period_start    (period_start),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: position within the current PWM period, in cycles.
  // A period lasts 2^R * (divider+1) cycles; the last cycle is the boundary.
  int m_pos = 0, m_fv = 0, m_duty = 0, m_target = 0, m_step = 0;
  bit m_ramp = 0, m_run = 0, m_done = 0;

  function automatic bit exp_ready();
    return m_run && (enable === 1'b1) && (!m_ramp || RETARGET);
  endfunction

  function automatic bit exp_bnd();
    return m_pos == FULL * (m_fv + 1) - 1;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pos = 0; m_fv = 0; m_duty = 0; m_target = 0; m_step = 0;
      m_ramp = 0; m_run = 0; m_done = 0;
    end else begin
      bit acc, bnd;
      int gap;
      acc = req_valid && exp_ready();
      bnd = exp_bnd();
      m_done = 0;
      if (bnd) begin
        if (!enable) begin
          m_duty = 0; m_target = 0; m_ramp = 0;
        end else if (m_ramp) begin
          gap = m_target - m_duty;
          if (gap < 0) gap = -gap;
          if (m_step == 0 || gap <= m_step) begin
            m_duty = m_target; m_done = 1; m_ramp = 0;
          end else if (m_target > m_duty) begin
            m_duty = m_duty + m_step;
          end else begin
            m_duty = m_duty - m_step;
          end
        end
        m_fv  = int'(cfg_final_value);
        m_pos = 0;
      end else begin
        m_pos++;
      end
      if (acc) begin
        m_target = (int'(req_duty) > FULL) ? FULL : int'(req_duty);
        m_step   = int'(req_step);
        m_ramp   = 1;
      end
      m_run = 1;
    end
  end

  always @(negedge clk) begin
    check_eq("duty",      pwm_duty,        m_duty);
    check_eq("final_val", pwm_final_value, m_fv);
    check_eq("per_start", period_start,    exp_bnd());
    check_eq("busy",      busy,            m_ramp);
    check_eq("done",      done,            m_done);
    check_eq("ready",     req_ready,       exp_ready());
  end

  int seen[$];

  task automatic step_cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_bnd(input int n);
    for (int i = 0; i < n; i++) begin
      int cnt;
      cnt = 0;
      while (period_start !== 1'b1 && cnt < 5000) begin
        step_cyc();
        cnt++;
      end
      if (cnt >= 5000) begin
        check_eq("bnd_timeout", cnt, 0);
        return;
      end
      step_cyc();
      seen.push_back(int'(pwm_duty));
    end
  endtask

  task automatic cycles_to_bnd(output int n);
    n = 0;
    while (period_start !== 1'b1 && n < 5000) begin
      step_cyc();
      n++;
    end
  endtask

  task automatic send(input int duty, input int stp);
    int cnt;
    cnt = 0;
    while (req_ready !== 1'b1 && cnt < 8000) begin
      step_cyc();
      cnt++;
    end
    if (cnt >= 8000) begin
      check_eq("send_timeout", cnt, 0);
      return;
    end
    req_valid = 1'b1;
    req_duty  = duty[R:0];
    req_step  = stp[R-1:0];
    step_cyc();
    req_valid = 1'b0;
  endtask

  initial begin
    int n1, n2, cnt;
    #1 reset_n = 1'b0;
    cfg_final_value = 16'd1;
    step_cyc();
    step_cyc();
    check_eq("rst_duty",  pwm_duty, 0);
    check_eq("rst_fv",    pwm_final_value, 0);
    check_eq("rst_ready", req_ready, 0);
    check_eq("rst_busy",  busy, 0);
    check_eq("rst_done",  done, 0);
    check_eq("rst_pstart", period_start, 0);
    reset_n = 1'b1;

    // 1: ramp up 0 -> 64 in steps of 16
    send(64, 16);
    seen.delete();
    wait_bnd(4);
    check_eq("t1_d16", seen[0], 16);
    check_eq("t1_d32", seen[1], 32);
    check_eq("t1_d48", seen[2], 48);
    check_eq("t1_d64", seen[3], 64);
    check_eq("t1_done", done, 1);
    check_eq("t1_busy", busy, 0);

    // 2: jump to 200, then ramp down to 190 by 4
    send(200, 0);
    seen.delete();
    wait_bnd(1);
    check_eq("t2_jump", seen[0], 200);
    send(190, 4);
    seen.delete();
    wait_bnd(3);
    check_eq("t2_d196", seen[0], 196);
    check_eq("t2_d192", seen[1], 192);
    check_eq("t2_d190", seen[2], 190);

    // 3: clamp
    send(300, 0);
    seen.delete();
    wait_bnd(1);
    check_eq("t3_clamp", seen[0], 256);

    // 4: divider change around phase 100
    repeat (199) step_cyc();
    cfg_final_value = 16'd3;
    check_eq("t4_fv_hold", pwm_final_value, 1);
    cycles_to_bnd(n1);
    check_eq("t4_gap512", 200 + n1, 512);
    step_cyc();
    check_eq("t4_fv_new", pwm_final_value, 3);
    cfg_final_value = 16'd0;
    cycles_to_bnd(n2);
    check_eq("t4_gap1024", 1 + n2, 1024);

    // 5: request taken on a boundary edge, then disable mid-ramp
    send(0, 32);
    seen.delete();
    wait_bnd(2);
    check_eq("t5_d224", seen[0], 224);
    check_eq("t5_d192", seen[1], 192);
    enable = 1'b0;
    #1;
    check_eq("t5_ready_off", req_ready, 0);
    seen.delete();
    wait_bnd(1);
    check_eq("t5_dis_duty", seen[0], 0);
    check_eq("t5_dis_done", done, 0);
    check_eq("t5_dis_busy", busy, 0);
    enable = 1'b1;

    // 5b: asynchronous reset mid-ramp
    cfg_final_value = 16'd1;
    send(100, 10);
    seen.delete();
    wait_bnd(1);
    check_eq("t5_d10", seen[0], 10);
    repeat (50) step_cyc();
    reset_n = 1'b0;
    #1;
    check_eq("t5_rst_duty", pwm_duty, 0);
    check_eq("t5_rst_fv", pwm_final_value, 0);
    check_eq("t5_rst_busy", busy, 0);
    check_eq("t5_rst_ready", req_ready, 0);
    repeat (3) step_cyc();
    reset_n = 1'b1;
    cfg_final_value = 16'd0;

    // 6: retarget while ramping
    send(128, 8);
    seen.delete();
    wait_bnd(2);
    check_eq("t6_d8", seen[0], 8);
    check_eq("t6_d16", seen[1], 16);
`ifdef PWM_RAMP_RETARGET_EN
    check_eq("t6_ready_ramp", req_ready, 1);
    send(0, 8);
    seen.delete();
    wait_bnd(2);
    check_eq("t6_back8", seen[0], 8);
    check_eq("t6_back0", seen[1], 0);
    check_eq("t6_done", done, 1);
`else
    check_eq("t6_ready_hold", req_ready, 0);
    check_eq("t6_busy", busy, 1);
    seen.delete();
    wait_bnd(14);
    check_eq("t6_final", seen[13], 128);
    check_eq("t6_done", done, 1);
`endif

    // Random phase, checked cycle by cycle against the model
    for (int i = 0; i < 20; i++) begin
      int d, s;
      cfg_final_value = ($urandom_range(0, 3) == 0) ? 16'd1 : 16'd0;
      if ($urandom_range(0, 5) == 0) begin
        enable = 1'b0;
        wait_bnd(1);
        enable = 1'b1;
      end
      if ($urandom_range(0, 3) == 0) begin
        cnt = 0;
        while (period_start !== 1'b1 && cnt < 2000) begin
          step_cyc();
          cnt++;
        end
      end
      d = int'($urandom_range(0, 300));
      s = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(32, 128));
      send(d, s);
      repeat ($urandom_range(1, 600)) step_cyc();
    end
    repeat (300) step_cyc();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
